// File: rtl/mem_latency_sim_queue.sv
// Simulation-side memory request delay queue: each accepted request is tagged with a
// latency (xorshift32-derived or fixed) and released strictly in order once it elapses.
module mem_latency_sim_queue #(
  parameter int          QUEUE_SIZE        = 128,
  parameter int          FLUCTUATION_RANGE = 10,
  parameter logic [31:0] RAND_SEED         = 32'd1987534242,
  parameter bit          RANDOM_ENABLE     = 1'b1,
  parameter int          FIXED_LATENCY     = 0,
  parameter int          ADDR_WIDTH        = 32,
  parameter int          DATA_WIDTH        = 64,
  parameter int          SERIAL_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pushIsRead,
  input  logic                          pushIsWrite,
  input  logic [ADDR_WIDTH-1:0]         pushAddr,
  input  logic [DATA_WIDTH-1:0]         pushWriteData,
  input  logic [SERIAL_WIDTH-1:0]       pushReadSerial,
  input  logic [SERIAL_WIDTH-1:0]       pushWriteSerial,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(QUEUE_SIZE):0]   count,
  output logic                          popValid,
  input  logic                          popReady,
  output logic                          popIsRead,
  output logic                          popIsWrite,
  output logic [ADDR_WIDTH-1:0]         popAddr,
  output logic [DATA_WIDTH-1:0]         popWriteData,
  output logic [SERIAL_WIDTH-1:0]       popReadSerial,
  output logic [SERIAL_WIDTH-1:0]       popWriteSerial
);

  localparam int          PW   = $clog2(QUEUE_SIZE);
  localparam int          CW   = PW + 1;
  localparam int          RW   = $clog2(FLUCTUATION_RANGE) + 1;
  localparam int          EW   = 2 + ADDR_WIDTH + DATA_WIDTH + 2 * SERIAL_WIDTH;
  localparam logic [31:0] FR32 = FLUCTUATION_RANGE;

  logic [EW-1:0]         r_mem [QUEUE_SIZE];
  logic [RW-1:0]         r_remain [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_rng;

  logic                    w_push_ok;
  logic                    w_pop;
  logic [RW-1:0]           w_lat;
  logic [31:0]             w_rng_a;
  logic [31:0]             w_rng_b;
  logic [31:0]             w_rng_next;
  logic [EW-1:0]           w_push_entry;
  logic [EW-1:0]           w_head_entry;
  logic                    w_h_rd;
  logic                    w_h_wr;
  logic [ADDR_WIDTH-1:0]   w_h_addr;
  logic [DATA_WIDTH-1:0]   w_h_data;
  logic [SERIAL_WIDTH-1:0] w_h_rser;
  logic [SERIAL_WIDTH-1:0] w_h_wser;

  assign full  = (r_count == CW'(QUEUE_SIZE));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Kind-less pushes are dropped entirely, including the RNG step.
  assign w_push_ok = push && !full && (pushIsRead || pushIsWrite);
  assign w_pop     = popValid && popReady;

  assign w_rng_a    = r_rng ^ (r_rng << 13);
  assign w_rng_b    = w_rng_a ^ (w_rng_a >> 17);
  assign w_rng_next = w_rng_b ^ (w_rng_b << 5);
  assign w_lat      = RANDOM_ENABLE ? RW'(r_rng % FR32) : RW'(FIXED_LATENCY);

  assign w_push_entry = {pushIsRead, pushIsWrite, pushAddr, pushWriteData,
                         pushReadSerial, pushWriteSerial};
  assign w_head_entry = r_mem[r_head];
  assign {w_h_rd, w_h_wr, w_h_addr, w_h_data, w_h_rser, w_h_wser} = w_head_entry;

  assign popValid       = !empty && (r_remain[r_head] == '0);
  assign popIsRead      = popValid && w_h_rd;
  assign popIsWrite     = popValid && w_h_wr;
  assign popAddr        = popValid ? w_h_addr : '0;
  assign popWriteData   = popValid ? w_h_data : '0;
  assign popReadSerial  = popValid ? w_h_rser : '0;
  assign popWriteSerial = popValid ? w_h_wser : '0;

  // Payload storage needs no reset: every field is gated by popValid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_tail] <= w_push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_rng   <= RAND_SEED;
      for (int i = 0; i < QUEUE_SIZE; i++) r_remain[i] <= '0;
    end else begin
      // All held entries age together so latencies overlap behind the head.
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (r_valid[i] && (r_remain[i] != '0)) r_remain[i] <= r_remain[i] - RW'(1);
      end
      if (w_push_ok) begin
        r_valid[r_tail]  <= 1'b1;
        r_remain[r_tail] <= w_lat;
        r_tail           <= r_tail + PW'(1);
        if (RANDOM_ENABLE) r_rng <= w_rng_next;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
